// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multicycle control path: opcodes, FSM states, mux selects and ALU ops.
package core_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEM_ADR = 4'd3,
        ST_MEM_RD  = 4'd4,
        ST_MEM_WB  = 4'd5,
        ST_MEM_WR  = 4'd6,
        ST_EXEC_R  = 4'd7,
        ST_EXEC_I  = 4'd8,
        ST_ALU_WB  = 4'd9,
        ST_BRANCH  = 4'd10,
        ST_JAL     = 4'd11,
        ST_FAULT   = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_REG   = 2'b10
    } srca_t;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } srcb_t;

    typedef enum logic [1:0] {
        RES_ALUOUT  = 2'b00,
        RES_MEMDATA = 2'b01
    } res_t;

    typedef struct packed {
        logic    pc_write;
        logic    ir_write;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    adr_src;
        srca_t   alu_src_a;
        srcb_t   alu_src_b;
        alu_op_t alu_op;
        res_t    result_src;
        logic    fault;
    } ctrl_t;

    // Unknown opcodes park the controller in FAULT rather than guessing a datapath path.
    function automatic state_t decode_target(input logic [6:0] op);
        state_t s;
        case (op)
            OP_LOAD, OP_STORE: s = ST_MEM_ADR;
            OP_RTYPE:          s = ST_EXEC_R;
            OP_ITYPE:          s = ST_EXEC_I;
            OP_BRANCH:         s = ST_BRANCH;
            OP_JAL:            s = ST_JAL;
            default:           s = ST_FAULT;
        endcase
        return s;
    endfunction

    function automatic state_t fetch_or_idle(input logic run);
        return run ? ST_FETCH : ST_IDLE;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: sequencing inputs, memory handshake, strobes and status.
interface multicycle_controller_if;
    logic        run;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;

    logic        pc_write;
    logic        ir_write;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        adr_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  result_src;
    logic        fault;
    logic [31:0] retired;

    modport master (
        input  run, opcode, zero, mem_ready,
        output pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
               alu_src_a, alu_src_b, alu_op, result_src, fault, retired
    );

    modport slave (
        output run, opcode, zero, mem_ready,
        input  pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
               alu_src_a, alu_src_b, alu_op, result_src, fault, retired
    );
endinterface

// File: rtl/ctrl_output_decode.sv
// Purpose: maps the controller state to datapath strobes and selects.
// Latency: purely combinational, same cycle as the state register.
// Backpressure: mem_ready only gates the FETCH PC update; zero gates the BRANCH PC update.
module ctrl_output_decode
    import core_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   zero,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = mem_ready;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM_ADR: begin
                ctrl.alu_src_a = SRCA_REG;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.adr_src  = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_MEMDATA;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.adr_src   = 1'b1;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = SRCA_REG;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a = SRCA_REG;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ST_ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a  = SRCA_REG;
                ctrl.alu_src_b  = SRCB_REG;
                ctrl.alu_op     = ALU_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = zero;
            end
            ST_JAL: begin
                // Target was computed in DECODE; this cycle forms the link value PC+4.
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
            end
            ST_FAULT: ctrl.fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: multicycle instruction sequencer FSM plus retired-instruction counter.
// Latency: strobes follow the state register combinationally; one state step per clock.
// Backpressure: FETCH, MEM_RD and MEM_WR hold until mem_ready; run is only sampled on entry to FETCH.
module multicycle_controller
    import core_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_controller_if.master  bus
);

    state_t      state_q;
    state_t      state_d;
    logic        retire;
    logic [31:0] retired_q;
    ctrl_t       ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE:    if (bus.run) state_d = ST_FETCH;
            ST_FETCH:   if (bus.mem_ready) state_d = ST_DECODE;
            ST_DECODE:  state_d = decode_target(bus.opcode);
            ST_MEM_ADR: state_d = (bus.opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:  if (bus.mem_ready) state_d = ST_MEM_WB;
            ST_MEM_WB: begin
                retire  = 1'b1;
                state_d = fetch_or_idle(bus.run);
            end
            ST_MEM_WR: begin
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = fetch_or_idle(bus.run);
                end
            end
            ST_EXEC_R,
            ST_EXEC_I:  state_d = ST_ALU_WB;
            ST_ALU_WB: begin
                retire  = 1'b1;
                state_d = fetch_or_idle(bus.run);
            end
            ST_BRANCH: begin
                retire  = 1'b1;
                state_d = fetch_or_idle(bus.run);
            end
            ST_JAL:     state_d = ST_ALU_WB;
            ST_FAULT:   state_d = ST_FAULT;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Counter wraps naturally at 32 bits; only written on a retiring transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 32'd0;
        end else if (retire) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    ctrl_output_decode u_decode (
        .state     (state_q),
        .zero      (bus.zero),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.pc_write   = ctrl.pc_write;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.adr_src    = ctrl.adr_src;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.result_src = ctrl.result_src;
    assign bus.fault      = ctrl.fault;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected cycle streams built from instruction recipes.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [6:0] I_LW  = 7'b0000011;
    localparam logic [6:0] I_SW  = 7'b0100011;
    localparam logic [6:0] I_R   = 7'b0110011;
    localparam logic [6:0] I_I   = 7'b0010011;
    localparam logic [6:0] I_BEQ = 7'b1100011;
    localparam logic [6:0] I_JAL = 7'b1101111;

    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEM_ADR = 3, P_MEM_RD = 4,
                   P_MEM_WB = 5, P_MEM_WR = 6, P_EXEC_R = 7, P_EXEC_I = 8, P_ALU_WB = 9,
                   P_BRANCH = 10, P_JAL = 11, P_FAULT = 12;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] exp_ret;
    bit          idle;

    // Vector layout: pc ir rw mrd mwr adr | src_a | src_b | alu_op | result | fault
    function automatic logic [14:0] expv(input int ph, input bit z, input bit mr);
        case (ph)
            P_FETCH:   return {mr,   5'b10100, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0};
            P_DECODE:  return {1'b0, 5'b00000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
            P_MEM_ADR: return {1'b0, 5'b00000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
            P_MEM_RD:  return {1'b0, 5'b00101, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
            P_MEM_WB:  return {1'b0, 5'b01000, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0};
            P_MEM_WR:  return {1'b0, 5'b00011, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
            P_EXEC_R:  return {1'b0, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
            P_EXEC_I:  return {1'b0, 5'b00000, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0};
            P_ALU_WB:  return {1'b0, 5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
            P_BRANCH:  return {z,    5'b00000, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
            P_JAL:     return {1'b1, 5'b00000, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
            P_FAULT:   return {1'b0, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
            default:   return 15'd0;
        endcase
    endfunction

    function automatic logic [14:0] obsv();
        return {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read, bus.mem_write,
                bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src, bus.fault};
    endfunction

    function automatic bit rb();
        return ($urandom & 32'd1) != 32'd0;
    endfunction

    task automatic check15(input string tag, input logic [14:0] o, input logic [14:0] e);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] o, input logic [31:0] e);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Called at a falling edge: drive inputs, check outputs, advance to the next falling edge.
    task automatic cyc(input int ph, input bit r, input bit z, input bit mr, input string tag);
        bus.run = r;
        bus.zero = z;
        bus.mem_ready = mr;
        #1;
        check15(tag, obsv(), expv(ph, z, mr));
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        bus.run = rb();
        bus.zero = rb();
        bus.mem_ready = rb();
        #1;
        check15({tag, " outputs"}, obsv(), 15'd0);
        check32({tag, " retired"}, bus.retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_ret = 32'd0;
        idle = 1'b1;
    endtask

    // Runs one instruction; fs/ms are stall cycles in FETCH and in the data access.
    task automatic exec(input logic [6:0] op, input int fs, input int ms, input bit z,
                        input bit r_end, input string nm);
        bit retires = 1'b1;
        bus.opcode = op;
        if (idle) cyc(P_IDLE, 1'b1, rb(), rb(), {nm, " idle"});
        idle = 1'b0;
        for (int i = 0; i < fs; i++) cyc(P_FETCH, rb(), rb(), 1'b0, {nm, " fetch stall"});
        cyc(P_FETCH, rb(), rb(), 1'b1, {nm, " fetch"});
        cyc(P_DECODE, rb(), rb(), rb(), {nm, " decode"});
        case (op)
            I_LW: begin
                cyc(P_MEM_ADR, rb(), rb(), rb(), {nm, " adr"});
                for (int i = 0; i < ms; i++) cyc(P_MEM_RD, rb(), rb(), 1'b0, {nm, " rd stall"});
                cyc(P_MEM_RD, rb(), rb(), 1'b1, {nm, " rd"});
                cyc(P_MEM_WB, r_end, rb(), rb(), {nm, " wb"});
            end
            I_SW: begin
                cyc(P_MEM_ADR, rb(), rb(), rb(), {nm, " adr"});
                for (int i = 0; i < ms; i++) cyc(P_MEM_WR, rb(), rb(), 1'b0, {nm, " wr stall"});
                cyc(P_MEM_WR, r_end, rb(), 1'b1, {nm, " wr"});
            end
            I_R: begin
                cyc(P_EXEC_R, rb(), rb(), rb(), {nm, " exec"});
                cyc(P_ALU_WB, r_end, rb(), rb(), {nm, " wb"});
            end
            I_I: begin
                cyc(P_EXEC_I, rb(), rb(), rb(), {nm, " exec"});
                cyc(P_ALU_WB, r_end, rb(), rb(), {nm, " wb"});
            end
            I_BEQ: cyc(P_BRANCH, r_end, z, rb(), {nm, " branch"});
            I_JAL: begin
                cyc(P_JAL, rb(), rb(), rb(), {nm, " jal"});
                cyc(P_ALU_WB, r_end, rb(), rb(), {nm, " wb"});
            end
            default: begin
                retires = 1'b0;
                for (int i = 0; i < 20; i++) cyc(P_FAULT, (i % 2) == 1, rb(), rb(), {nm, " fault hold"});
            end
        endcase
        if (retires) begin
            exp_ret = exp_ret + 32'd1;
            idle = !r_end;
        end
        check32({nm, " retired"}, bus.retired, exp_ret);
    endtask

    logic [6:0] ops [6];

    initial begin
        ops[0] = I_LW; ops[1] = I_SW; ops[2] = I_R;
        ops[3] = I_I;  ops[4] = I_BEQ; ops[5] = I_JAL;
        bus.run = 1'b0;
        bus.opcode = 7'd0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        exp_ret = 32'd0;
        idle = 1'b1;

        // Reset state, then idle holds while run is low.
        rst_n = 1'b0;
        #1;
        check15("reset outputs", obsv(), 15'd0);
        check32("reset retired", bus.retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(P_IDLE, 1'b0, rb(), rb(), "idle run low");
        cyc(P_IDLE, 1'b0, rb(), rb(), "idle run low 2");

        // Directed instructions.
        exec(I_R,   0, 0, 1'b0, 1'b1, "rtype");
        exec(I_LW,  0, 3, 1'b0, 1'b1, "lw stall3");
        exec(I_BEQ, 0, 0, 1'b1, 1'b1, "beq taken");
        exec(I_BEQ, 0, 0, 1'b0, 1'b1, "beq not taken");
        exec(I_JAL, 1, 0, 1'b0, 1'b1, "jal");
        exec(I_I,   0, 0, 1'b0, 1'b1, "itype");
        exec(I_SW,  2, 2, 1'b0, 1'b0, "sw to idle");
        cyc(P_IDLE, 1'b0, rb(), rb(), "idle after stop");
        cyc(P_IDLE, 1'b0, rb(), rb(), "idle after stop 2");

        // Randomized instruction mix with random stalls and stop points.
        for (int n = 0; n < 30; n++) begin
            exec(ops[$urandom_range(5, 0)], int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
                 rb(), ($urandom_range(3, 0) != 0), $sformatf("rand%0d", n));
        end

        // Reset while a store is stalled waiting for memory.
        bus.opcode = I_SW;
        if (idle) cyc(P_IDLE, 1'b1, rb(), rb(), "abort idle");
        cyc(P_FETCH, 1'b1, rb(), 1'b1, "abort fetch");
        cyc(P_DECODE, 1'b1, rb(), rb(), "abort decode");
        cyc(P_MEM_ADR, 1'b1, rb(), rb(), "abort adr");
        cyc(P_MEM_WR, 1'b1, rb(), 1'b0, "abort wr stall");
        cyc(P_MEM_WR, 1'b1, rb(), 1'b0, "abort wr stall 2");
        do_reset("mid store reset");
        cyc(P_IDLE, 1'b0, rb(), rb(), "idle after abort");

        // Counter wrap from all-ones.
        bus.run = 1'b0;
        force dut.retired_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retired_q;
        exp_ret = 32'hFFFF_FFFF;
        check32("preload retired", bus.retired, exp_ret);
        exec(I_SW, 1, 1, 1'b0, 1'b0, "sw wrap");
        check32("wrap to zero", bus.retired, 32'd0);

        // Illegal opcode sticks in FAULT until reset.
        exec(7'b0000000, 0, 0, 1'b0, 1'b1, "illegal");
        do_reset("fault reset");
        cyc(P_IDLE, 1'b0, rb(), rb(), "idle after fault");
        exec(I_R, 0, 0, 1'b0, 1'b0, "rtype after fault");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: run  input  1  level; start/continue sequencing from IDLE.
REQ-004 SHALL have port: opcode  input  7  instruction[6:0], held stable by the IR after FETCH.
REQ-005 SHALL have port: zero  input  1  ALU zero flag, sampled in BRANCH.
REQ-006 SHALL have port: mem_ready  input  1  memory handshake; access completes in the cycle it is high.
REQ-007 SHALL have ports: pc_write, ir_write, reg_write, mem_read, mem_write, adr_src  output  1 each  datapath strobes/selects.
REQ-008 SHALL have ports: alu_src_a, alu_src_b, alu_op, result_src  output  2 each  datapath mux/ALU controls.
REQ-009 SHALL have ports: fault  output  1  sticky illegal-opcode flag; retired  output  32  instructions completed.

Function
REQ-010 SHALL implement a Moore FSM; all control outputs SHALL decode from the state register only; zero/mem_ready SHALL affect only next-state and pc_write.
REQ-011 States SHALL be: IDLE, FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, FAULT.
REQ-012 IDLE: all strobes 0; -> FETCH when run=1.
REQ-013 FETCH: mem_read=1, adr_src=0; SHALL stay while mem_ready=0; on mem_ready=1: ir_write=1, pc_write=1 (PC+4, alu_src_a=00, alu_src_b=10, alu_op=00), -> DECODE.
REQ-014 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target); next by opcode: 0000011/0100011 -> MEM_ADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL; any other -> FAULT.
REQ-015 MEM_ADR: alu_src_a=10, alu_src_b=01, alu_op=00; -> MEM_RD if opcode=0000011, else MEM_WR.
REQ-016 MEM_RD: mem_read=1, adr_src=1; stall while mem_ready=0; -> MEM_WB on mem_ready=1.
REQ-017 MEM_WB: reg_write=1, result_src=01; -> FETCH.
REQ-018 MEM_WR: mem_write=1, adr_src=1, held until mem_ready=1; -> FETCH.
REQ-019 EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10; EXEC_I: alu_src_a=10, alu_src_b=01, alu_op=10; both -> ALU_WB.
REQ-020 ALU_WB: reg_write=1, result_src=00; -> FETCH.
REQ-021 BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00; pc_write=zero; -> FETCH.
REQ-022 JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1; -> ALU_WB.
REQ-023 Every transition into FETCH SHALL test run: run=0 -> IDLE instead; a running instruction SHALL always complete.
REQ-024 retired SHALL increment by 1 on each transition from MEM_WB, MEM_WR, ALU_WB or BRANCH; SHALL wrap 0xFFFFFFFF -> 0.
REQ-025 FAULT: all strobes 0, fault=1, SHALL remain until reset regardless of run.
REQ-026 Unlisted outputs in any state SHALL be 0; no strobe SHALL be X in any reachable state.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, retired=0, fault=0, all strobes/selects 0, including mid-instruction or mid-stall.
REQ-028 After rst_n deassertion the first FETCH SHALL occur one cycle after run=1 is sampled.

Structure
REQ-029 Opcode constants, state encoding enum and alu_op/select encodings SHALL live in shared package core_ctrl_pkg.
REQ-030 Output decode SHALL be a sub-module ctrl_output_decode (state -> strobes); FSM and counter in the top.

Verification
REQ-031 Reset then run=1, opcode=0110011, mem_ready=1 always -> IDLE,FETCH,DECODE,EXEC_R,ALU_WB,FETCH; reg_write high 1 cycle; retired=1.
REQ-032 lw with mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, mem_read/adr_src=1 throughout, then MEM_WB reg_write=1, result_src=01.
REQ-033 beq with zero=1 then zero=0 -> pc_write=1 in first BRANCH, 0 in second; retired=2.
REQ-034 opcode=0000000 -> DECODE->FAULT, fault=1 held 20 cycles with run toggling; rst_n pulse clears to IDLE.
REQ-035 rst_n asserted mid MEM_WR stall -> outputs 0 same cycle, retired=0; run=0 at instruction end -> IDLE.
REQ-036 Preload retired=0xFFFFFFFF via force, retire one sw -> retired=0.
